// File: rtl/replay_ctrl.sv
// replay_ctrl: replays a queue of grid moves (up/right/down/left) as a
// valid/ready stream while tracking the resulting position. A move that would
// leave the grid is never offered downstream; the run stops in ERR instead.
module replay_ctrl #(
    parameter int X_W     = 4,
    parameter int Y_W     = 4,
    parameter int START_X = 0,
    parameter int START_Y = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           q_empty,
    input  logic [1:0]     q_data,
    output logic           q_deq,
    output logic           move_valid,
    input  logic           move_ready,
    output logic [1:0]     move_dir,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic [8:0]     step_cnt,
    output logic           busy,
    output logic           done,
    output logic           err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [X_W-1:0] X_INIT = X_W'(START_X);
    localparam logic [Y_W-1:0] Y_INIT = Y_W'(START_Y);
    localparam logic [X_W-1:0] X_ONE  = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);
    localparam logic [X_W-1:0] X_MAX  = {X_W{1'b1}};
    localparam logic [Y_W-1:0] Y_MAX  = {Y_W{1'b1}};
    localparam logic [8:0]     CNT_MAX = 9'd511;

    state_t         state_q, state_d;
    logic [1:0]     dir_q, dir_d;
    logic [X_W-1:0] x_q, x_d, tx;
    logic [Y_W-1:0] y_q, y_d, ty;
    logic [8:0]     cnt_q, cnt_d;
    logic           oob;

    // Target of the latched move and whether it would fall off the grid.
    always_comb begin
        tx  = x_q;
        ty  = y_q;
        oob = 1'b0;
        case (dir_q)
            2'b00: begin
                oob = (y_q == '0);
                ty  = y_q - Y_ONE;
            end
            2'b01: begin
                oob = (x_q == X_MAX);
                tx  = x_q + X_ONE;
            end
            2'b10: begin
                oob = (y_q == Y_MAX);
                ty  = y_q + Y_ONE;
            end
            default: begin
                oob = (x_q == '0);
                tx  = x_q - X_ONE;
            end
        endcase
    end

    // Next-state logic: FETCH -> WAIT -> ISSUE per move, DONE on empty queue.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    x_d     = X_INIT;
                    y_d     = Y_INIT;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = q_empty ? S_DONE : S_WAIT;
            S_WAIT: begin
                // Queue read data arrives the cycle after the dequeue strobe.
                dir_d   = q_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (oob) begin
                    state_d = S_ERR;
                end else if (move_ready) begin
                    x_d     = tx;
                    y_d     = ty;
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 9'd1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any run in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            dir_q   <= 2'b00;
            x_q     <= X_INIT;
            y_q     <= Y_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    // An out-of-grid move is withheld so downstream never accepts it.
    assign q_deq      = (state_q == S_FETCH) && !q_empty;
    assign move_valid = (state_q == S_ISSUE) && !oob;
    assign move_dir   = dir_q;
    assign pos_x      = x_q;
    assign pos_y      = y_q;
    assign step_cnt   = cnt_q;
    assign busy       = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_ISSUE);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);

endmodule

// File: tb/tb_replay_ctrl.sv
// tb_replay_ctrl: scenario tasks against a behavioural direction queue;
// accepted moves are predicted into a scoreboard and matched to handshakes.
module tb_replay_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       q_empty;
    logic [1:0] q_data = 2'b00;
    logic       q_deq;
    logic       move_valid;
    logic       move_ready = 1'b1;
    logic [1:0] move_dir;
    logic [3:0] pos_x, pos_y;
    logic [8:0] step_cnt;
    logic       busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    // Queue model: bench appends at qwr, DUT drains at qrd.
    logic [1:0] qmem [0:4095];
    int qwr = 0;
    int qrd = 0;
    logic [1:0] exp_q [$];

    // Handshake / strobe monitor.
    logic [1:0] hs_dir [0:4095];
    int hs_wr = 0;
    int hs_rd = 0;
    int deq_cnt = 0;
    int deq_dbl = 0;
    logic deq_prev = 1'b0;
    int done_cnt = 0;

    replay_ctrl #(.X_W(4), .Y_W(4), .START_X(0), .START_Y(0)) dut (
        .clk(clk), .rst(rst), .start(start), .q_empty(q_empty), .q_data(q_data),
        .q_deq(q_deq), .move_valid(move_valid), .move_ready(move_ready),
        .move_dir(move_dir), .pos_x(pos_x), .pos_y(pos_y), .step_cnt(step_cnt),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign q_empty = (qrd == qwr);

    always @(posedge clk) begin
        if (q_deq) begin
            q_data <= qmem[qrd];
            qrd    <= qrd + 1;
        end
    end

    always @(negedge clk) begin
        if (move_valid && move_ready) begin
            hs_dir[hs_wr] <= move_dir;
            hs_wr <= hs_wr + 1;
        end
        if (q_deq) deq_cnt <= deq_cnt + 1;
        if (q_deq && deq_prev) deq_dbl <= deq_dbl + 1;
        deq_prev <= q_deq;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic push_move(input logic [1:0] d, input bit accepted);
        qmem[qwr] = d;
        qwr++;
        if (accepted) exp_q.push_back(d);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_not_busy(input int maxc, output int ncyc, output bit to);
        ncyc = 0;
        to = 1'b1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            ncyc++;
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int maxc, output bit to);
        to = 1'b1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (move_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int deq0;
        #1 rst = 1'b0;
        #4;
        n_tests++; if (q_deq !== 1'b0) begin n_fail++; $display("FAIL rst_q_deq got %b exp 0", q_deq); end
        n_tests++; if (move_valid !== 1'b0) begin n_fail++; $display("FAIL rst_move_valid got %b exp 0", move_valid); end
        n_tests++; if (move_dir !== 2'b00) begin n_fail++; $display("FAIL rst_move_dir got %b exp 00", move_dir); end
        n_tests++; if (pos_x !== 4'd0 || pos_y !== 4'd0) begin n_fail++; $display("FAIL rst_pos got (%0d,%0d) exp (0,0)", pos_x, pos_y); end
        n_tests++; if (step_cnt !== 9'd0) begin n_fail++; $display("FAIL rst_step got %0d exp 0", step_cnt); end
        n_tests++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b exp 000", {busy, done, err}); end
        @(negedge clk); rst = 1'b1;
        deq0 = deq_cnt;
        repeat (6) @(negedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got %b exp 0", busy); end
        n_tests++; if (deq_cnt !== deq0) begin n_fail++; $display("FAIL rst_idle_deq got %0d exp %0d", deq_cnt, deq0); end
    endtask

    task automatic test_basic();
        int ncyc, deq0, hs0, done0;
        bit to;
        logic [1:0] e;
        move_ready = 1'b1;
        push_move(2'b01, 1'b1);
        push_move(2'b01, 1'b1);
        push_move(2'b10, 1'b1);
        deq0 = deq_cnt; hs0 = hs_wr; done0 = done_cnt;
        pulse_start();
        wait_not_busy(60, ncyc, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %b exp 0", to); end
        n_tests++; if (ncyc !== 11) begin n_fail++; $display("FAIL basic_cycles got %0d exp 11", ncyc); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b exp 1", done); end
        n_tests++; if (pos_x !== 4'd2 || pos_y !== 4'd1) begin n_fail++; $display("FAIL basic_pos got (%0d,%0d) exp (2,1)", pos_x, pos_y); end
        n_tests++; if (step_cnt !== 9'd3) begin n_fail++; $display("FAIL basic_step got %0d exp 3", step_cnt); end
        @(posedge clk); #2;
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b exp 0", done); end
        n_tests++; if (done_cnt - done0 !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d exp 1", done_cnt - done0); end
        n_tests++; if (deq_cnt - deq0 !== 3) begin n_fail++; $display("FAIL basic_deq_count got %0d exp 3", deq_cnt - deq0); end
        n_tests++; if (hs_wr - hs0 !== 3) begin n_fail++; $display("FAIL basic_hs_count got %0d exp 3", hs_wr - hs0); end
        while (exp_q.size() > 0 && hs_rd < hs_wr) begin
            e = exp_q.pop_front();
            n_tests++; if (hs_dir[hs_rd] !== e) begin n_fail++; $display("FAIL basic_dir got %b exp %b", hs_dir[hs_rd], e); end
            hs_rd++;
        end
    endtask

    task automatic test_empty();
        int ncyc, deq0;
        bit to;
        deq0 = deq_cnt;
        pulse_start();
        wait_not_busy(20, ncyc, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL empty_timeout got %b exp 0", to); end
        n_tests++; if (ncyc !== 2) begin n_fail++; $display("FAIL empty_cycles got %0d exp 2", ncyc); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL empty_done got %b exp 1", done); end
        n_tests++; if (pos_x !== 4'd0 || pos_y !== 4'd0) begin n_fail++; $display("FAIL empty_pos got (%0d,%0d) exp (0,0)", pos_x, pos_y); end
        @(posedge clk); #2;
        n_tests++; if (deq_cnt !== deq0) begin n_fail++; $display("FAIL empty_deq got %0d exp %0d", deq_cnt, deq0); end
    endtask

    task automatic test_err();
        int ncyc, hs0;
        bit to;
        logic [1:0] e;
        move_ready = 1'b1;
        push_move(2'b00, 1'b0);
        hs0 = hs_wr;
        pulse_start();
        wait_not_busy(30, ncyc, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL err_timeout got %b exp 0", to); end
        n_tests++; if (err !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL err_flag got err=%b done=%b exp err=1 done=0", err, done); end
        n_tests++; if (pos_x !== 4'd0 || pos_y !== 4'd0) begin n_fail++; $display("FAIL err_pos got (%0d,%0d) exp (0,0)", pos_x, pos_y); end
        n_tests++; if (step_cnt !== 9'd0) begin n_fail++; $display("FAIL err_step got %0d exp 0", step_cnt); end
        repeat (3) @(negedge clk);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_held got %b exp 1", err); end
        n_tests++; if (hs_wr !== hs0) begin n_fail++; $display("FAIL err_no_hs got %0d exp %0d", hs_wr - hs0, 0); end
        push_move(2'b01, 1'b1);
        pulse_start();
        #1;
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", err); end
        wait_not_busy(30, ncyc, to);
        n_tests++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL err_restart_done got done=%b err=%b exp done=1 err=0", done, err); end
        n_tests++; if (pos_x !== 4'd1 || pos_y !== 4'd0) begin n_fail++; $display("FAIL err_restart_pos got (%0d,%0d) exp (1,0)", pos_x, pos_y); end
        @(posedge clk); #2;
        while (exp_q.size() > 0 && hs_rd < hs_wr) begin
            e = exp_q.pop_front();
            n_tests++; if (hs_dir[hs_rd] !== e) begin n_fail++; $display("FAIL err_dir got %b exp %b", hs_dir[hs_rd], e); end
            hs_rd++;
        end
    endtask

    task automatic test_stall();
        int ncyc;
        bit to;
        logic [1:0] e;
        move_ready = 1'b0;
        push_move(2'b01, 1'b1);
        pulse_start();
        wait_valid(20, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall_timeout got %b exp 0", to); end
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (move_valid !== 1'b1 || move_dir !== 2'b01) begin n_fail++; $display("FAIL stall_hold got v=%b d=%b exp v=1 d=01", move_valid, move_dir); end
            n_tests++; if (pos_x !== 4'd0) begin n_fail++; $display("FAIL stall_pos got %0d exp 0", pos_x); end
            @(negedge clk);
        end
        @(posedge clk); #1 move_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (pos_x !== 4'd0 || move_valid !== 1'b1) begin n_fail++; $display("FAIL stall_pre_hs got x=%0d v=%b exp x=0 v=1", pos_x, move_valid); end
        @(negedge clk);
        n_tests++; if (pos_x !== 4'd1 || step_cnt !== 9'd1) begin n_fail++; $display("FAIL stall_post_hs got x=%0d s=%0d exp x=1 s=1", pos_x, step_cnt); end
        wait_not_busy(20, ncyc, to);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_done got %b exp 1", done); end
        @(posedge clk); #2;
        while (exp_q.size() > 0 && hs_rd < hs_wr) begin
            e = exp_q.pop_front();
            n_tests++; if (hs_dir[hs_rd] !== e) begin n_fail++; $display("FAIL stall_dir got %b exp %b", hs_dir[hs_rd], e); end
            hs_rd++;
        end
    endtask

    task automatic test_reset_mid();
        int deq0;
        bit to;
        move_ready = 1'b0;
        push_move(2'b01, 1'b0);
        pulse_start();
        wait_valid(20, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rmid_timeout got %b exp 0", to); end
        #2 rst = 1'b0;
        #1;
        n_tests++; if ({q_deq, move_valid, busy, done, err} !== 5'b00000) begin n_fail++; $display("FAIL rmid_flags got %b exp 00000", {q_deq, move_valid, busy, done, err}); end
        n_tests++; if (move_dir !== 2'b00 || pos_x !== 4'd0 || pos_y !== 4'd0 || step_cnt !== 9'd0) begin n_fail++; $display("FAIL rmid_data got d=%b (%0d,%0d) s=%0d exp d=00 (0,0) s=0", move_dir, pos_x, pos_y, step_cnt); end
        deq0 = deq_cnt;
        @(negedge clk); rst = 1'b1;
        move_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        n_tests++; if (deq_cnt !== deq0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_idle got deq=%0d busy=%b exp deq=%0d busy=0", deq_cnt, busy, deq0); end
    endtask

    task automatic test_edge();
        int ncyc, hs0;
        bit to;
        logic [1:0] e;
        move_ready = 1'b1;
        for (int i = 0; i < 15; i++) push_move(2'b01, 1'b1);
        push_move(2'b01, 1'b0);
        hs0 = hs_wr;
        pulse_start();
        wait_not_busy(100, ncyc, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL edge_timeout got %b exp 0", to); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL edge_err got %b exp 1", err); end
        n_tests++; if (pos_x !== 4'd15 || step_cnt !== 9'd15) begin n_fail++; $display("FAIL edge_pos got x=%0d s=%0d exp x=15 s=15", pos_x, step_cnt); end
        @(posedge clk); #2;
        n_tests++; if (hs_wr - hs0 !== 15) begin n_fail++; $display("FAIL edge_hs got %0d exp 15", hs_wr - hs0); end
        while (exp_q.size() > 0 && hs_rd < hs_wr) begin
            e = exp_q.pop_front();
            n_tests++; if (hs_dir[hs_rd] !== e) begin n_fail++; $display("FAIL edge_dir got %b exp %b", hs_dir[hs_rd], e); end
            hs_rd++;
        end
    endtask

    task automatic test_long();
        int ncyc;
        bit to;
        logic [1:0] e;
        move_ready = 1'b1;
        for (int i = 0; i < 256; i++) push_move((i % 2 == 0) ? 2'b01 : 2'b11, 1'b1);
        pulse_start();
        wait_not_busy(900, ncyc, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL long256_timeout got %b exp 0", to); end
        n_tests++; if (step_cnt !== 9'd256 || done !== 1'b1) begin n_fail++; $display("FAIL long256_step got %0d done=%b exp 256 done=1", step_cnt, done); end
        n_tests++; if (pos_x !== 4'd0 || pos_y !== 4'd0) begin n_fail++; $display("FAIL long256_pos got (%0d,%0d) exp (0,0)", pos_x, pos_y); end
        for (int i = 0; i < 520; i++) push_move((i % 2 == 0) ? 2'b10 : 2'b00, 1'b1);
        pulse_start();
        wait_not_busy(1800, ncyc, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL long520_timeout got %b exp 0", to); end
        n_tests++; if (step_cnt !== 9'd511) begin n_fail++; $display("FAIL long520_sat got %0d exp 511", step_cnt); end
        @(posedge clk); #2;
        n_tests++; if (exp_q.size() !== hs_wr - hs_rd) begin n_fail++; $display("FAIL long_hs_count got %0d exp %0d", hs_wr - hs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && hs_rd < hs_wr) begin
            e = exp_q.pop_front();
            n_tests++; if (hs_dir[hs_rd] !== e) begin n_fail++; $display("FAIL long_dir got %b exp %b", hs_dir[hs_rd], e); end
            hs_rd++;
        end
        n_tests++; if (deq_dbl !== 0) begin n_fail++; $display("FAIL deq_back_to_back got %0d exp 0", deq_dbl); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_err();
        test_stall();
        test_reset_mid();
        test_edge();
        test_long();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
